sysid_info_regs: RTL and testbench

Parametrised Avalon-MM system-identification and info slave for the lab SoC. It replaces the constant ID/timestamp responder with a registered read path and several extra words: a free-running 64-bit uptime counter with atomic snapshot, a read/write scratch register, and a capability word. Software uses it to confirm the hardware build, measure elapsed cycles and sanity-check bus access.

---
 rtl/sysid_info_regs.sv | 77 +++++++
 tb/tb_sysid_info_regs.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sysid_info_regs.sv
// System ID / info slave: registered Avalon-MM read path over ID, timestamp,
// a 2*DATA_W uptime counter with coherent high-half snapshot, scratch and capability.
module sysid_info_regs #(
  parameter logic [31:0] ID           = 32'h5A987835,
  parameter logic [31:0] TIMESTAMP    = 32'h00000000,
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 3,
  parameter logic [31:0] SCRATCH_INIT = 32'h00000000,
  parameter logic [7:0]  VERSION      = 8'h02
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  localparam int CNT_W = 2 * DATA_W;
  localparam logic [31:0] CAP32 = {VERSION, 8'(ADDR_W), 16'(DATA_W)};

  logic [CNT_W-1:0]  uptime_q, uptime_d;
  logic [DATA_W-1:0] snap_hi_q, snap_hi_d;
  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvld_q, rvld_d;
  logic [DATA_W-1:0] rd_word;

  // Word 2 returns the pre-increment count; word 3 only ever shows the latched half.
  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_W'(0): rd_word = DATA_W'(ID);
      ADDR_W'(1): rd_word = DATA_W'(TIMESTAMP);
      ADDR_W'(2): rd_word = uptime_q[DATA_W-1:0];
      ADDR_W'(3): rd_word = snap_hi_q;
      ADDR_W'(4): rd_word = scratch_q;
      ADDR_W'(5): rd_word = DATA_W'(CAP32);
      default:    rd_word = '0;
    endcase
  end

  always_comb begin
    uptime_d  = uptime_q + CNT_W'(1);
    snap_hi_d = snap_hi_q;
    scratch_d = scratch_q;
    rdata_d   = rdata_q;
    rvld_d    = read;
    if (read) begin
      rdata_d = rd_word;
      if (address == ADDR_W'(2)) snap_hi_d = uptime_q[CNT_W-1:DATA_W];
    end
    if (write && address == ADDR_W'(4)) scratch_d = writedata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime_q  <= '0;
      snap_hi_q <= '0;
      scratch_q <= DATA_W'(SCRATCH_INIT);
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
    end else begin
      uptime_q  <= uptime_d;
      snap_hi_q <= snap_hi_d;
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      rvld_q    <= rvld_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvld_q;

endmodule

// File: tb/tb_sysid_info_regs.sv
// Bench for sysid_info_regs: directed scenarios plus random traffic against a word-map model.
module tb_sysid_info_regs;
  localparam logic [31:0] ID  = 32'h5A987835;
  localparam logic [31:0] TS  = 32'h00000000;
  localparam logic [31:0] SI  = 32'h00000000;
  localparam logic [31:0] CAP = 32'h02030020;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int checks = 0, failures = 0;

  // Model: cycles since reset release, latched high half, scratch, last returned word.
  longint unsigned m_up;
  logic [31:0] m_snap, m_scr, m_last;

  sysid_info_regs dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [2:0] a);
    case (a)
      3'd0: return ID;
      3'd1: return TS;
      3'd2: return m_up[31:0];
      3'd3: return m_snap;
      3'd4: return m_scr;
      3'd5: return CAP;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_reset();
    m_up = 0; m_snap = '0; m_scr = SI; m_last = '0;
  endfunction

  // Caller is positioned between edges; one access spans exactly one rising edge.
  task automatic cyc(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
    read = r; write = w; address = a; writedata = d;
    @(posedge clock); #1;
    if (r) begin
      m_last = word(a);
      if (a == 3'd2) m_snap = m_up[63:32];
    end
    if (w && a == 3'd4) m_scr = d;
    m_up++;
    chk("rvld", {63'b0, readdatavalid}, {63'b0, r});
    chk("rdata", {32'b0, readdata}, {32'b0, m_last});
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_rvld", {63'b0, readdatavalid}, 64'd0);
    chk("rst_rdata", {32'b0, readdata}, 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    repeat (3) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); chk("id", {32'b0, readdata}, {32'b0, ID});
    cyc(1, 0, 1, 0); chk("ts", {32'b0, readdata}, {32'b0, TS});
    cyc(1, 0, 5, 0); chk("cap", {32'b0, readdata}, {32'b0, CAP});
    cyc(0, 0, 0, 0);

    cyc(1, 0, 4, 0); chk("scr_init", {32'b0, readdata}, {32'b0, SI});
    cyc(0, 1, 4, 32'hDEADBEEF);
    cyc(1, 0, 4, 0); chk("scr_wr", {32'b0, readdata}, 64'hDEADBEEF);
    cyc(0, 1, 0, 32'h12345678);
    cyc(1, 0, 0, 0); chk("ro_id", {32'b0, readdata}, {32'b0, ID});

    force dut.uptime_q = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.uptime_q;
    m_up = 64'h0000_0000_FFFF_FFFE;
    cyc(1, 0, 2, 0); chk("snap_lo", {32'b0, readdata}, 64'hFFFFFFFE);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(1, 0, 3, 0); chk("snap_hi0", {32'b0, readdata}, 64'h0);
    cyc(1, 0, 2, 0);
    cyc(1, 0, 3, 0); chk("snap_hi1", {32'b0, readdata}, 64'h1);

    cyc(0, 1, 4, 32'h11111111);
    cyc(1, 1, 4, 32'hA5A5A5A5); chk("rw_old", {32'b0, readdata}, 64'h11111111);
    cyc(1, 0, 4, 0); chk("rw_new", {32'b0, readdata}, 64'hA5A5A5A5);

    cyc(1, 0, 6, 0); chk("addr6", {32'b0, readdata}, 64'h0);
    cyc(1, 0, 7, 0); chk("addr7", {32'b0, readdata}, 64'h0);

    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), $urandom);

    cyc(0, 1, 4, 32'hCAFEF00D);
    cyc(1, 0, 4, 0); chk("pre_rst", {32'b0, readdata}, 64'hCAFEF00D);
    #2 reset = 1'b1;
    #1;
    chk("arst_rvld", {63'b0, readdatavalid}, 64'd0);
    chk("arst_rdata", {32'b0, readdata}, 64'd0);
    model_reset();
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    cyc(1, 0, 2, 0);
    chk("up_small", {63'b0, (readdata < 32'd5)}, 64'd1);
    cyc(1, 0, 4, 0); chk("scr_rst", {32'b0, readdata}, {32'b0, SI});
    cyc(1, 0, 3, 0); chk("snap_rst", {32'b0, readdata}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
